prbs_generator_par: RTL and testbench
=====================================

# prbs_generator_par

Parallel, parametrised PRBS/pattern source. Each enabled cycle it produces `n_ways` bits of a programmable-polynomial Fibonacci LFSR sequence, or a fixed or clock pattern. It adds seed/pause control, positioned one-shot error injection, an injection counter, and zero-lockup recovery. It drives the transmit serializer datapath in `digital_top` as the wide-word source.

## Interface
- `n_prbs`, 32, LFSR length in bits.
- `n_ways`, 16, bits emitted per cycle (≥1, ≤`n_prbs` not required).
- `n_cnt`, 16, width of the injection counter.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset. There is one clock, and reset is asynchronous and active-low.
- `cke`  in  1  run enable. Low pauses the block.
- `reseed`  in  1  pulse. Forces reload from `init_val`.
- `init_val`  in  `n_prbs`  LFSR seed.
- `eqn`  in  `n_prbs`  tap mask.
- `mode`  in  2  0 = PRBS, 1 = fixed pattern, 2 = clock pattern, 3 = zeros.
- `pattern`  in  `n_ways`  word used in mode 1.
- `inj_err`  in  1  error-injection request (level, edge-detected).
- `inj_pos`  in  `$clog2(n_ways)`  bit index to flip.
- `inv_chicken`  in  2  bit 0: invert all bits. Bit 1: reverse bit order in the word.
- `out`  out  `n_ways`  data word. `out[0]` is the earliest bit.
- `out_valid`  out  1  `out` holds a new word this cycle.
- `inj_cnt`  out  `n_cnt`  saturating count of injected errors.
- `zero_lock`  out  1  sticky flag: the LFSR reached the all-zero state.

## Operation
- **LFSR step:** `b = ^(s & eqn)`, then `s <= {s[n_prbs-2:0], b}`. The emitted bit is `b`.
- **PRBS word:** `n_ways` successive steps per cycle. Step k produces `out[k]`.
- **FSM states:** IDLE, LOAD, RUN, PAUSE.
  - IDLE → LOAD when `cke` = 1.
  - LOAD (one cycle): `s <= init_val`, then → RUN.
  - RUN: each cycle, emit a word and set `out_valid` = 1.
  - RUN → PAUSE when `cke` = 0.
  - PAUSE → RUN when `cke` = 1. The sequence continues without a reload.
  - `reseed` = 1 in any state → LOAD. It takes priority over `cke`.
- **In PAUSE and IDLE:** `s` is frozen, `out` holds its last value, and `out_valid` = 0.
- **Non-PRBS modes (1–3):** `s` is frozen, and the word is `pattern`, `{n_ways/2{2'b10}}` (`out[0]` = 0), or 0 respectively. `mode` changes take effect on the next emitted word.
- **Zero lockup:** in RUN with mode 0 and `s` == 0, the next cycle behaves as LOAD (reload `init_val`, no word emitted) and sets `zero_lock`. `zero_lock` is cleared only by reset. If `init_val` = 0, this repeats every other cycle.
- **Error injection:**
  - A rising edge of `inj_err` (registered previous value) while in RUN arms a one-shot.
  - The next emitted word has bit `inj_pos` flipped. The flip is applied after inversion and reversal, at the final position.
  - `inj_cnt` increments and saturates at all-ones.
  - An edge outside RUN is dropped and not counted.
  - A new edge while already armed is merged: one flip, one count.
- **Output transforms:** order is data, then reverse (`inv_chicken[1]`), then invert (`inv_chicken[0]`), then injection. All apply in every mode.
- **Reset values:** state IDLE, `s` = 0, `out` = 0, `out_valid` = 0, `inj_cnt` = 0, `zero_lock` = 0, armed = 0, `inj_err` edge register = 0.

## Timing
- `out`, `out_valid`, `inj_cnt` and `zero_lock` are registered. There is no combinational input-to-output path.
- **Start-up:** `cke` is first sampled high at edge E0 and the FSM enters LOAD. At E1, `s` = `init_val` and the FSM enters RUN. At E2, the first word is on `out` with `out_valid` = 1.
- Steady state is one word per cycle.
- `cke` sampled low at edge E: the word from E is the last valid word, and `out_valid` = 0 after E+1.
- `inj_err` rising, sampled at E: the flipped word appears at E+1, and `inj_cnt` updates at E+1.
- `reseed` sampled at E: `out_valid` = 0 after E+1, and the first reseeded word appears at E+2.
- `rst_n` assertion mid-run clears all state immediately. Release is synchronised externally.

## Structure
- Shared package `prbs_pkg` holds:
  - `prbs_mode_t` (the 2-bit mode enum);
  - `prbs_state_t` (IDLE/LOAD/RUN/PAUSE);
  - the localparam clock-pattern helper.
- Sub-module `prbs_step_unroll`: purely combinational. Inputs are `s` and `eqn`. Outputs are the `n_ways`-bit word and the next `s`, computed by a generate-unrolled step chain.
- The top level holds the FSM, the output transforms and the counters.

## Test plan
- PRBS7, `n_ways` = 8, `eqn` = 32'h60, `init_val` = 1, `cke` high → first word 8'h60. The bit stream has a 127-bit period and matches the reference model for 1000 words.
- Same setup with `inv_chicken` = 2'b11 → first word 8'hF9. `inj_err` pulse with `inj_pos` = 3 → exactly one word has bit 3 flipped and `inj_cnt` = 1. Ten pulses while `cke` = 0 → `inj_cnt` unchanged.
- `cke` low for 5 cycles mid-run, then high → the stream resumes with no gap or repeat versus the model. `out_valid` is low for exactly the paused cycles.
- `init_val` = 0 in mode 0 → `zero_lock` = 1 and `out_valid` never rises. `rst_n` low → `zero_lock` = 0 and all outputs 0.
- Mode switching 0 → 1 (`pattern` = 8'hA5) → 2 → 0 → `out` = A5, then 8'hAA, then the PRBS resumes from its frozen state.
- `reseed` mid-run, simultaneous with an `inj_err` edge → the injection is dropped and not counted. The sequence restarts at 8'h60 two cycles later.

Source files
------------

// File: rtl/prbs_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// prbs_pkg: shared types and constants for the parallel PRBS source. Rev 1.0
// -----------------------------------------------------------------------------
package prbs_pkg;

  typedef enum logic [1:0] {
    MODE_PRBS  = 2'd0,
    MODE_FIXED = 2'd1,
    MODE_CLOCK = 2'd2,
    MODE_ZERO  = 2'd3
  } prbs_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_PAUSE = 2'd3
  } prbs_state_t;

  // Alternating 0/1 word with the earliest bit low; sliced down to n_ways.
  localparam int                    c_MAX_WAYS    = 256;
  localparam logic [c_MAX_WAYS-1:0] c_CLK_PATTERN = {(c_MAX_WAYS / 2){2'b10}};

endpackage
`default_nettype wire

// File: rtl/prbs_step_unroll.sv
`default_nettype none
// -----------------------------------------------------------------------------
// prbs_step_unroll: n_ways Fibonacci LFSR steps unrolled in one cycle. Rev 1.0
// -----------------------------------------------------------------------------
module prbs_step_unroll #(
  parameter int n_prbs = 32,
  parameter int n_ways = 16
) (
  input  logic [n_prbs-1:0] s_i,
  input  logic [n_prbs-1:0] eqn_i,
  output logic [n_ways-1:0] word_o,
  output logic [n_prbs-1:0] s_next_o
);

  // Each stage owns its own state vector so the chain is not one wide net.
  for (genvar k = 0; k < n_ways; k++) begin : g_step
    logic [n_prbs-1:0] w_cur;
    logic              w_b;
    if (k == 0) begin : g_first
      assign w_cur = s_i;
    end else begin : g_next
      assign w_cur = {g_step[k-1].w_cur[n_prbs-2:0], g_step[k-1].w_b};
    end
    assign w_b       = ^(w_cur & eqn_i);
    assign word_o[k] = w_b;
  end

  assign s_next_o = {g_step[n_ways-1].w_cur[n_prbs-2:0], g_step[n_ways-1].w_b};

endmodule
`default_nettype wire

// File: rtl/prbs_generator_par.sv
`default_nettype none
// -----------------------------------------------------------------------------
// prbs_generator_par: parallel PRBS / pattern word source with injection. Rev 1.0
// -----------------------------------------------------------------------------
module prbs_generator_par
  import prbs_pkg::*;
#(
  parameter int n_prbs = 32,
  parameter int n_ways = 16,
  parameter int n_cnt  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cke,
  input  logic                      reseed,
  input  logic [n_prbs-1:0]         init_val,
  input  logic [n_prbs-1:0]         eqn,
  input  logic [1:0]                mode,
  input  logic [n_ways-1:0]         pattern,
  input  logic                      inj_err,
  input  logic [$clog2(n_ways)-1:0] inj_pos,
  input  logic [1:0]                inv_chicken,
  output logic [n_ways-1:0]         out,
  output logic                      out_valid,
  output logic [n_cnt-1:0]          inj_cnt,
  output logic                      zero_lock
);

  prbs_state_t       state_q;
  logic [n_prbs-1:0] s_q;
  logic [n_prbs-1:0] s_d;
  logic [n_ways-1:0] out_q;
  logic [n_ways-1:0] out_d;
  logic              out_valid_q;
  logic [n_cnt-1:0]  inj_cnt_q;
  logic              zero_lock_q;
  logic              armed_q;
  logic              inj_err_q;

  logic [n_ways-1:0] w_prbs_word;
  logic [n_ways-1:0] w_data;
  logic [n_ways-1:0] w_shaped;
  logic              w_prbs_mode;
  logic              w_lockup;
  logic              w_inj_rise;

  prbs_step_unroll #(
    .n_prbs (n_prbs),
    .n_ways (n_ways)
  ) u_step (
    .s_i      (s_q),
    .eqn_i    (eqn),
    .word_o   (w_prbs_word),
    .s_next_o (s_d)
  );

  assign w_prbs_mode = (prbs_mode_t'(mode) == MODE_PRBS);
  assign w_lockup    = w_prbs_mode && (s_q == '0);
  assign w_inj_rise  = inj_err && !inj_err_q;

  always_comb begin
    case (prbs_mode_t'(mode))
      MODE_PRBS:  w_data = w_prbs_word;
      MODE_FIXED: w_data = pattern;
      MODE_CLOCK: w_data = c_CLK_PATTERN[n_ways-1:0];
      default:    w_data = '0;
    endcase
    w_shaped = inv_chicken[1] ? {<<{w_data}} : w_data;
    if (inv_chicken[0]) begin
      w_shaped = ~w_shaped;
    end
    out_d = w_shaped;
    if (armed_q) begin
      out_d[inj_pos] = ~out_d[inj_pos];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      s_q         <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      inj_cnt_q   <= '0;
      zero_lock_q <= 1'b0;
      armed_q     <= 1'b0;
      inj_err_q   <= 1'b0;
    end else begin
      inj_err_q   <= inj_err;
      out_valid_q <= 1'b0;
      if (reseed) begin
        state_q <= ST_LOAD;
        armed_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (cke) state_q <= ST_LOAD;
          end
          ST_LOAD: begin
            s_q     <= init_val;
            state_q <= ST_RUN;
          end
          ST_RUN: begin
            if (w_lockup) begin
              // Stuck LFSR: spend a cycle reloading instead of emitting zeros.
              state_q     <= ST_LOAD;
              zero_lock_q <= 1'b1;
              if (w_inj_rise) armed_q <= 1'b1;
            end else begin
              out_q       <= out_d;
              out_valid_q <= 1'b1;
              if (w_prbs_mode) s_q <= s_d;
              if (armed_q) begin
                armed_q <= 1'b0;
                if (inj_cnt_q != '1) inj_cnt_q <= inj_cnt_q + n_cnt'(1);
              end else if (w_inj_rise) begin
                armed_q <= 1'b1;
              end
              if (!cke) state_q <= ST_PAUSE;
            end
          end
          ST_PAUSE: begin
            if (cke) state_q <= ST_RUN;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign inj_cnt   = inj_cnt_q;
  assign zero_lock = zero_lock_q;

endmodule
`default_nettype wire

// File: tb/tb_prbs_generator_par.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_prbs_generator_par: scoreboard bench with a serial-recurrence PRBS model. Rev 1.0
// -----------------------------------------------------------------------------
module tb_prbs_generator_par;

  localparam int NP = 32;
  localparam int NW = 8;
  localparam int NC = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cke;
  logic          reseed;
  logic [NP-1:0] init_val;
  logic [NP-1:0] eqn;
  logic [1:0]    mode;
  logic [NW-1:0] pattern;
  logic          inj_err;
  logic [2:0]    inj_pos;
  logic [1:0]    inv_chicken;
  logic [NW-1:0] out;
  logic          out_valid;
  logic [NC-1:0] inj_cnt;
  logic          zero_lock;

  prbs_generator_par #(
    .n_prbs (NP),
    .n_ways (NW),
    .n_cnt  (NC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cke         (cke),
    .reseed      (reseed),
    .init_val    (init_val),
    .eqn         (eqn),
    .mode        (mode),
    .pattern     (pattern),
    .inj_err     (inj_err),
    .inj_pos     (inj_pos),
    .inv_chicken (inv_chicken),
    .out         (out),
    .out_valid   (out_valid),
    .inj_cnt     (inj_cnt),
    .zero_lock   (zero_lock)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NW-1:0] word;
    logic [NC-1:0] cnt;
  } exp_t;

  int            vectors = 0;
  int            errors  = 0;
  exp_t          sb[$];
  bit            hist[$];      // emitted bit sequence, newest at the back
  bit            armed_m;
  bit            inj_prev_m;
  int unsigned   cnt_m;
  logic [NW-1:0] last_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // The register window s[i] is the bit emitted i+1 steps ago.
  task automatic model_seed(input logic [NP-1:0] v);
    hist.delete();
    for (int i = NP - 1; i >= 0; i--) hist.push_back(v[i]);
  endtask

  task automatic model_bit(output bit b);
    b = 1'b0;
    for (int i = 0; i < NP; i++) if (eqn[i]) b ^= hist[hist.size() - 1 - i];
    hist.push_back(b);
    if (hist.size() > 2 * NP) void'(hist.pop_front());
  endtask

  task automatic model_word(output logic [NW-1:0] w);
    logic [NW-1:0] d;
    bit            b;
    d = '0;
    case (mode)
      2'd0: for (int k = 0; k < NW; k++) begin model_bit(b); d[k] = b; end
      2'd1: d = pattern;
      2'd2: for (int k = 0; k < NW; k++) d[k] = (k % 2 == 1);
      default: d = '0;
    endcase
    for (int k = 0; k < NW; k++) w[k] = inv_chicken[1] ? d[NW - 1 - k] : d[k];
    if (inv_chicken[0]) w = ~w;
  endtask

  // One clock edge; 'emit' says whether the spec's timing produces a word at it.
  task automatic tick(input bit emit);
    exp_t          e;
    logic [NW-1:0] w;
    bit            rise;
    rise = inj_err && !inj_prev_m;
    if (emit) begin
      model_word(w);
      if (armed_m) begin
        w[inj_pos] = ~w[inj_pos];
        armed_m    = 1'b0;
        if (cnt_m < (1 << NC) - 1) cnt_m++;
      end else if (rise) begin
        armed_m = 1'b1;
      end
      e.word   = w;
      e.cnt    = cnt_m[NC-1:0];
      last_exp = w;
      sb.push_back(e);
    end
    inj_prev_m = inj_err;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reseed();
    reseed = 1'b1;
    tick(1'b0);
    reseed  = 1'b0;
    armed_m = 1'b0;
    model_seed(init_val);
    tick(1'b0);
    check("reseed_gap_valid", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic do_pause(input int p);
    int lows;
    lows = 0;
    cke  = 1'b0;
    tick(1'b1);
    for (int i = 1; i < p; i++) begin
      tick(1'b0);
      if (!out_valid) lows++;
    end
    check("pause_hold_out", {24'd0, out}, {24'd0, last_exp});
    cke = 1'b1;
    tick(1'b0);
    if (!out_valid) lows++;
    check("pause_low_cycles", lows, p);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        vectors++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: out=%h with no word expected", out);
        end else begin
          e = sb.pop_front();
          if (out !== e.word || inj_cnt !== e.cnt) begin
            errors++;
            $display("FAIL word: out=%h inj_cnt=%0d, expected out=%h inj_cnt=%0d",
                     out, inj_cnt, e.word, e.cnt);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached, %0d vectors so far", vectors);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst_n = 1'b0; cke = 1'b0; reseed = 1'b0; inj_err = 1'b0; inj_pos = '0;
    init_val = 32'd1; eqn = 32'h60; mode = 2'd0; pattern = '0; inv_chicken = 2'b00;
    armed_m = 1'b0; inj_prev_m = 1'b0; cnt_m = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", {24'd0, out}, 32'd0);
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    check("reset_inj_cnt", {16'd0, inj_cnt}, 32'd0);
    check("reset_zero_lock", {31'd0, zero_lock}, 32'd0);
    rst_n = 1'b1;
    model_seed(init_val);

    // Start-up: LOAD at E0, RUN at E1, first word after E2.
    cke = 1'b1;
    tick(1'b0);
    tick(1'b0);
    tick(1'b1);
    check("first_word", {24'd0, out}, 32'h60);
    repeat (999) tick(1'b1);

    do_reseed();
    inv_chicken = 2'b11;
    tick(1'b1);
    check("first_word_inv_rev", {24'd0, out}, 32'hF9);

    inj_pos = 3'd3; inj_err = 1'b1;
    tick(1'b1);
    inj_err = 1'b0;
    repeat (3) tick(1'b1);
    check("inj_cnt_one", {16'd0, inj_cnt}, 32'd1);

    cke = 1'b0;
    tick(1'b1);
    for (int i = 0; i < 10; i++) begin
      inj_err = 1'b1; tick(1'b0);
      inj_err = 1'b0; tick(1'b0);
    end
    cke = 1'b1;
    tick(1'b0);
    check("inj_cnt_paused_pulses", {16'd0, inj_cnt}, 32'd1);
    repeat (10) tick(1'b1);

    inv_chicken = 2'b00;
    repeat (4) tick(1'b1);
    do_pause(5);
    repeat (20) tick(1'b1);

    mode = 2'd1; pattern = 8'hA5;
    tick(1'b1);
    check("mode_fixed", {24'd0, out}, 32'hA5);
    mode = 2'd2;
    tick(1'b1);
    check("mode_clock", {24'd0, out}, 32'hAA);
    mode = 2'd0;
    repeat (20) tick(1'b1);

    inj_err = 1'b1; reseed = 1'b1;
    tick(1'b0);
    reseed = 1'b0; armed_m = 1'b0;
    model_seed(init_val);
    tick(1'b0);
    inj_err = 1'b0;
    tick(1'b1);
    check("reseed_restart", {24'd0, out}, 32'h60);
    check("reseed_inj_dropped", {16'd0, inj_cnt}, 32'd1);
    repeat (5) tick(1'b1);

    for (int it = 0; it < 300; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 5) begin
        case ($urandom_range(0, 2))
          0:       eqn = 32'h0000_0060;
          1:       eqn = 32'h0000_6000;
          default: eqn = 32'h4800_0000;
        endcase
        init_val = $urandom | 32'd1;
        do_reseed();
      end else if (r < 10) begin
        do_pause($urandom_range(1, 6));
      end else begin
        mode        = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        pattern     = 8'($urandom);
        inv_chicken = 2'($urandom);
        inj_pos     = 3'($urandom);
        inj_err     = ($urandom_range(0, 9) == 0);
        tick(1'b1);
      end
    end
    inj_err = 1'b0; mode = 2'd0;
    tick(1'b1);
    check("no_zero_lock_in_run", {31'd0, zero_lock}, 32'd0);

    eqn = 32'h60; init_val = 32'd0;
    do_reseed();
    repeat (20) tick(1'b0);
    check("zero_lock_set", {31'd0, zero_lock}, 32'd1);

    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_zero_lock", {31'd0, zero_lock}, 32'd0);
    check("async_rst_out", {24'd0, out}, 32'd0);
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_inj_cnt", {16'd0, inj_cnt}, 32'd0);

    @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
